// File: rtl/cv32e40s_obi_trans_handler.sv
// OBI master-side A/R channel driver: turns a valid/ready transaction request
// into OBI requests, holds the payload stable until grant and bounds the
// number of granted-but-unanswered transactions.
module cv32e40s_obi_trans_handler #(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  // core side
  input  logic             trans_valid_i,
  output logic             trans_ready_o,
  input  logic [31:0]      trans_addr_i,
  input  logic             trans_we_i,
  input  logic [3:0]       trans_be_i,
  input  logic [31:0]      trans_wdata_i,
  output logic             resp_valid_o,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_err_o,
  // OBI side
  output logic             obi_req_o,
  input  logic             obi_gnt_i,
  output logic [31:0]      obi_addr_o,
  output logic             obi_we_o,
  output logic [3:0]       obi_be_o,
  output logic [31:0]      obi_wdata_o,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  input  logic             obi_err_i,
  // status
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o
);

  typedef enum logic {
    ST_TRANSPARENT,
    ST_REGISTERED
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } payload_t;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  payload_t         r_payload;
  payload_t         w_payload_in;
  payload_t         w_payload_out;
  logic             w_ready;
  logic             w_accept;
  logic             w_capture;
  logic             w_inc;
  logic             w_dec;

  assign w_payload_in = '{addr: trans_addr_i, we: trans_we_i, be: trans_be_i, wdata: trans_wdata_i};

  // Ready only while no request is parked and a new one cannot overflow the counter.
  assign w_ready  = !rst && (r_state == ST_TRANSPARENT) && (r_count < CNT_W'(MAX_OUTSTANDING));
  assign w_accept = trans_valid_i && w_ready;

  // Next-state and request/payload selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    obi_req_o     = 1'b0;
    w_payload_out = w_payload_in;
    unique case (r_state)
      ST_TRANSPARENT: begin
        obi_req_o = w_accept;
        if (w_accept && !obi_gnt_i) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_REGISTERED;
        end
      end
      ST_REGISTERED: begin
        // Request may only be withdrawn without a grant under reset.
        obi_req_o     = !rst;
        w_payload_out = r_payload;
        if (obi_gnt_i) begin
          w_state_nxt = ST_TRANSPARENT;
        end
      end
      default: w_state_nxt = ST_TRANSPARENT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      r_state <= ST_TRANSPARENT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload register, loaded only when a request is parked waiting for grant.
  always_ff @(posedge clk) begin
    // NOTE: a single control register (not a memory array) is cheap to reset, so it is.
    if (rst) begin
      r_payload <= '0;
    end else if (w_capture) begin
      r_payload <= w_payload_in;
    end
  end

  // Outstanding counter: +1 on granted request, -1 on response; a stray response at 0 is ignored.
  assign w_inc = obi_req_o && obi_gnt_i;
  assign w_dec = obi_rvalid_i && (r_count != '0);

  // Outstanding counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_inc && !w_dec) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_dec && !w_inc) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign obi_addr_o    = w_payload_out.addr;
  assign obi_we_o      = w_payload_out.we;
  assign obi_be_o      = w_payload_out.be;
  assign obi_wdata_o   = w_payload_out.wdata;

  assign trans_ready_o = w_ready;
  assign resp_valid_o  = obi_rvalid_i;
  assign resp_rdata_o  = obi_rdata_i;
  assign resp_err_o    = obi_err_i;
  assign outstanding_o = r_count;
  assign busy_o        = (r_count != '0) || (r_state == ST_REGISTERED);

  // Protocol checks.
  a_req_stable : assert property (@(posedge clk) disable iff (rst)
    obi_req_o && !obi_gnt_i |=> obi_req_o && $stable(obi_addr_o) && $stable(obi_we_o)
                                && $stable(obi_be_o) && $stable(obi_wdata_o));

  a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
    r_count <= CNT_W'(MAX_OUTSTANDING));

  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (rst)
    obi_rvalid_i |-> r_count != '0);

endmodule
